// File: rtl/ep_bulk_in_pkg.sv
// Shared USB end-point definitions: FSM state encoding and max packet sizes.
// Latency: none (package only).
// Backpressure: not applicable.
package ep_bulk_in_pkg;

   // End-point FSM states; ST_ZERO is only reachable when ZDP support is built in
   typedef enum logic [2:0] {
      ST_HALT = 3'd0,
      ST_IDLE = 3'd1,
      ST_SEND = 3'd2,
      ST_ZERO = 3'd3,
      ST_WAIT = 3'd4
   } ep_state_t;

   // Bulk max payload sizes for high-speed and full-speed links
   localparam int USB_HS_MAX_PACKET = 512;
   localparam int USB_FS_MAX_PACKET = 64;

endpackage

// File: rtl/ep_bulk_in_packet_fifo.sv
// Packet FIFO: stores words with a last flag; the read side only sees saved (committed) words.
// Latency: a saved word reaches rd_* one cycle after it becomes visible, then one word per cycle.
// Backpressure: wr_rdy_o drops when DEPTH words (incl. un-freed packets) are held; rd_* hold while rd_rdy_i=0.
module ep_bulk_in_packet_fifo #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 2048,
   parameter bit STORE_LASTS  = 1'b1,
   parameter bit SAVE_ON_LAST = 1'b1,
   parameter bit NEXT_ON_LAST = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             wr_vld_i,
   output logic             wr_rdy_o,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             wr_last_i,
   input  logic             save_i,
   input  logic             redo_i,
   input  logic             next_i,
   output logic             rd_vld_o,
   input  logic             rd_rdy_i,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic             rd_last_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH:0] mem_q [DEPTH];
   logic [WIDTH:0] out_q;
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    saved_q, saved_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]    start_q, start_d;
   logic           out_vld_q, out_vld_d;
   logic           hold_q, hold_d;
   logic [AW:0]    used;
   logic           wr_en, save_now, consume, out_last, blocked, fetch;

   // Pointer bookkeeping: start_q marks the packet being sent, so its space stays reserved until freed
   always_comb begin
      used      = wr_ptr_q - start_q;
      wr_rdy_o  = !used[AW];
      wr_en     = wr_vld_i && wr_rdy_o && !clear_i;
      save_now  = save_i || (SAVE_ON_LAST && wr_en && wr_last_i);
      out_last  = out_q[WIDTH];
      consume   = out_vld_q && rd_rdy_i;
      // Stop at a packet boundary until the packet is freed or rewound
      blocked   = !NEXT_ON_LAST && (hold_q || (out_vld_q && out_last));
      fetch     = (rd_ptr_q != saved_q) && !blocked && (!out_vld_q || consume)
                  && !clear_i && !redo_i;

      wr_ptr_d  = wr_ptr_q;
      saved_d   = saved_q;
      rd_ptr_d  = rd_ptr_q;
      start_d   = start_q;
      out_vld_d = out_vld_q;
      hold_d    = hold_q;

      if (clear_i) begin
         wr_ptr_d  = '0;
         saved_d   = '0;
         rd_ptr_d  = '0;
         start_d   = '0;
         out_vld_d = 1'b0;
         hold_d    = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (save_now) saved_d = wr_ptr_d;
         if (redo_i) begin
            rd_ptr_d  = start_q;
            out_vld_d = 1'b0;
            hold_d    = 1'b0;
         end else begin
            if (next_i) begin
               start_d = rd_ptr_q;
               hold_d  = 1'b0;
            end
            if (fetch) begin
               rd_ptr_d  = rd_ptr_q + 1'b1;
               out_vld_d = 1'b1;
            end else if (consume) begin
               out_vld_d = 1'b0;
               if (out_last && !NEXT_ON_LAST) hold_d = 1'b1;
            end
         end
      end
   end

   // Storage array and registered read port (no reset, RAM style)
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {(STORE_LASTS ? wr_last_i : 1'b0), wr_dat_i};
      if (fetch) out_q <= mem_q[rd_ptr_q[AW-1:0]];
   end

   // Control state registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         saved_q   <= '0;
         rd_ptr_q  <= '0;
         start_q   <= '0;
         out_vld_q <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         saved_q   <= saved_d;
         rd_ptr_q  <= rd_ptr_d;
         start_q   <= start_d;
         out_vld_q <= out_vld_d;
         hold_q    <= hold_d;
      end
   end

   assign rd_vld_o  = out_vld_q;
   assign rd_dat_o  = out_q[WIDTH-1:0];
   assign rd_last_o = out_q[WIDTH];

endmodule

// File: rtl/ep_bulk_in.sv
// Bulk IN end-point: segments a byte stream into USB packets, resends until ACKed, tracks DATA0/1.
// Latency: ep_ready_o follows a packet commit by 2 cycles; packet bytes stream 1 per cycle once selected.
// Backpressure: s_tready drops when the FIFO is full; m_* hold while m_tready=0. Optional ZDP: BULK_IN_ZDP_EN.
module ep_bulk_in #(
   parameter int USB_MAX_PACKET_SIZE = ep_bulk_in_pkg::USB_HS_MAX_PACKET,
   parameter int PACKET_FIFO_DEPTH   = 2048,
   parameter bit ENABLED             = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       set_conf_i,
   input  logic       clr_conf_i,
   input  logic       selected_i,
   input  logic       ack_recv_i,
   input  logic       timedout_i,
   output logic       ep_ready_o,
   output logic       stalled_o,
   output logic       parity_o,
   input  logic       s_tvalid,
   output logic       s_tready,
   input  logic       s_tlast,
   input  logic [7:0] s_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tlast,
   output logic       m_tkeep,
   output logic [7:0] m_tdata
);
   import ep_bulk_in_pkg::*;

   localparam int CW = $clog2(USB_MAX_PACKET_SIZE) + 1;
   localparam int PW = $clog2(PACKET_FIFO_DEPTH) + 1;
`ifdef BULK_IN_ZDP_EN
   localparam int FW = 9;   // byte plus "frame ended on a full packet" flag
`else
   localparam int FW = 8;
`endif

   ep_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [PW-1:0] pkts_q, pkts_d;
   logic          parity_q, parity_d;
   logic          ready_q, ready_d;
   logic          zdp_pend, zdp_sent;

   logic          conf_evt, s_acc, at_max, commit;
   logic          in_send, in_zero, in_wait, beat_last, ack, tmo, data_ack;
   logic          f_wr_rdy, f_rd_vld, f_rd_rdy, f_rd_last;
   logic [FW-1:0] f_wr_dat, f_rd_dat;

`ifdef BULK_IN_ZDP_EN
   logic zdp_q, zdp_d;
   logic zsent_q, zsent_d;
   logic zflag_q, zflag_d;
   assign zdp_pend = zdp_q;
   assign zdp_sent = zsent_q;
`else
   assign zdp_pend = 1'b0;
   assign zdp_sent = 1'b0;
`endif

   // Ingress acceptance, byte counting and packet commit detection
   always_comb begin
      conf_evt = set_conf_i || clr_conf_i;
      s_tready = (state_q != ST_HALT) && !conf_evt && f_wr_rdy;
      s_acc    = s_tvalid && s_tready;
      cnt_inc  = cnt_q + 1'b1;
      at_max   = (cnt_inc == CW'(USB_MAX_PACKET_SIZE));
      commit   = s_acc && (s_tlast || at_max);
`ifdef BULK_IN_ZDP_EN
      f_wr_dat = {s_tlast && at_max, s_tdata};
`else
      f_wr_dat = s_tdata;
`endif
   end

   // Egress beat formatting and handshake decode
   always_comb begin
      in_send   = (state_q == ST_SEND);
      in_zero   = (state_q == ST_ZERO);
      in_wait   = (state_q == ST_WAIT);
      m_tvalid  = (in_send && f_rd_vld) || in_zero;
      m_tkeep   = in_send && f_rd_vld;
      m_tlast   = (in_send && f_rd_vld && f_rd_last) || in_zero;
      m_tdata   = (in_send && f_rd_vld) ? f_rd_dat[7:0] : 8'h00;
      f_rd_rdy  = in_send && m_tready;
      beat_last = in_send && f_rd_vld && f_rd_last && m_tready;
      ack       = in_wait && ack_recv_i;
      tmo       = in_wait && timedout_i && !ack_recv_i;
      data_ack  = ack && !zdp_sent;
   end

   // Next-state logic for the FSM, counters and parity
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HALT: if (set_conf_i) state_d = ST_IDLE;
         ST_IDLE: begin
            if (selected_i && ready_q) begin
               if (pkts_q != '0) state_d = ST_SEND;
`ifdef BULK_IN_ZDP_EN
               else if (zdp_q) state_d = ST_ZERO;
`endif
            end
         end
         ST_SEND: if (beat_last) state_d = ST_WAIT;
`ifdef BULK_IN_ZDP_EN
         ST_ZERO: if (m_tready) state_d = ST_WAIT;
`endif
         ST_WAIT: if (ack_recv_i || timedout_i) state_d = ST_IDLE;
         default: state_d = ST_HALT;
      endcase
      if (set_conf_i) state_d = ST_IDLE;
      if (clr_conf_i || !ENABLED) state_d = ST_HALT;

      cnt_d = cnt_q;
      if (s_acc) cnt_d = commit ? '0 : cnt_inc;
      if (conf_evt) cnt_d = '0;

      // Commit and ACK in the same cycle cancel out
      pkts_d = pkts_q;
      if (commit && !data_ack) pkts_d = pkts_q + 1'b1;
      else if (!commit && data_ack) pkts_d = pkts_q - 1'b1;
      if (conf_evt) pkts_d = '0;

      parity_d = parity_q;
      if (ack) parity_d = !parity_q;
      if (conf_evt) parity_d = 1'b0;

      ready_d = ((pkts_q != '0) || zdp_pend) && (state_q == ST_IDLE) && !conf_evt;

`ifdef BULK_IN_ZDP_EN
      zflag_d = zflag_q;
      if (beat_last) zflag_d = f_rd_dat[8];
      zsent_d = zsent_q;
      if (state_q == ST_IDLE) zsent_d = (state_d == ST_ZERO);
      zdp_d = zdp_q;
      if (ack) begin
         if (zsent_q) zdp_d = 1'b0;
         else if (zflag_q) zdp_d = 1'b1;
      end
      if (conf_evt) zdp_d = 1'b0;
`endif
   end

   // State registers; reset lands in HALT with an empty end-point
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_HALT;
         cnt_q    <= '0;
         pkts_q   <= '0;
         parity_q <= 1'b0;
         ready_q  <= 1'b0;
`ifdef BULK_IN_ZDP_EN
         zdp_q    <= 1'b0;
         zsent_q  <= 1'b0;
         zflag_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pkts_q   <= pkts_d;
         parity_q <= parity_d;
         ready_q  <= ready_d;
`ifdef BULK_IN_ZDP_EN
         zdp_q    <= zdp_d;
         zsent_q  <= zsent_d;
         zflag_q  <= zflag_d;
`endif
      end
   end

   ep_bulk_in_packet_fifo #(
      .WIDTH        (FW),
      .DEPTH        (PACKET_FIFO_DEPTH),
      .STORE_LASTS  (1'b1),
      .SAVE_ON_LAST (1'b1),
      .NEXT_ON_LAST (1'b0)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear_i   (conf_evt),
      .wr_vld_i  (s_acc),
      .wr_rdy_o  (f_wr_rdy),
      .wr_dat_i  (f_wr_dat),
      .wr_last_i (s_tlast || at_max),
      .save_i    (commit),
      .redo_i    (tmo && !zdp_sent),
      .next_i    (data_ack),
      .rd_vld_o  (f_rd_vld),
      .rd_rdy_i  (f_rd_rdy),
      .rd_dat_o  (f_rd_dat),
      .rd_last_o (f_rd_last)
   );

   assign ep_ready_o = ready_q;
   assign stalled_o  = (state_q == ST_HALT);
   assign parity_o   = parity_q;

endmodule

// File: tb/tb_ep_bulk_in.sv
// Directed bench for ep_bulk_in: segmentation, retransmit, parity, FIFO full and HALT behaviour.
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled at that point or at the falling edge.
// Backpressure: the source waits on s_tready; the sink drives m_tready directly.
module tb_ep_bulk_in;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       set_conf_i = 1'b0, clr_conf_i = 1'b0, selected_i = 1'b0;
   logic       ack_recv_i = 1'b0, timedout_i = 1'b0;
   logic       ep_ready_o, stalled_o, parity_o;
   logic       s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [7:0] s_tdata = 8'h00;
   logic       m_tvalid, m_tready = 1'b1, m_tlast, m_tkeep;
   logic [7:0] m_tdata;
   int         checks = 0;
   int         errors = 0;

   always #5 clock = ~clock;

   ep_bulk_in dut (
      .clock      (clock),
      .reset      (reset),
      .set_conf_i (set_conf_i),
      .clr_conf_i (clr_conf_i),
      .selected_i (selected_i),
      .ack_recv_i (ack_recv_i),
      .timedout_i (timedout_i),
      .ep_ready_o (ep_ready_o),
      .stalled_o  (stalled_o),
      .parity_o   (parity_o),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tlast    (s_tlast),
      .s_tdata    (s_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .m_tkeep    (m_tkeep),
      .m_tdata    (m_tdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic conf();
      set_conf_i = 1'b1;
      step();
      set_conf_i = 1'b0;
      step();
   endtask

   task automatic pulse_ack();
      ack_recv_i = 1'b1;
      step();
      ack_recv_i = 1'b0;
   endtask

   task automatic pulse_tmo();
      timedout_i = 1'b1;
      step();
      timedout_i = 1'b0;
   endtask

   // Byte g of a stream; the high part of g is folded in so 256-byte aliases differ
   function automatic logic [7:0] pat(input int g, input logic [7:0] base);
      return 8'(g + (g >> 8) + int'(base));
   endfunction

   task automatic push(input int n, input logic [7:0] base, input bit with_last);
      int   i = 0;
      int   guard = 0;
      logic acc;
      while (i < n && guard < 5000) begin
         s_tvalid = 1'b1;
         s_tdata  = pat(i, base);
         s_tlast  = with_last && (i == n - 1);
         @(negedge clock);
         acc = s_tready;
         step();
         guard++;
         if (acc === 1'b1) i++;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      chk("push_count", 32'(i), 32'(n));
   endtask

   // Wait for ep_ready_o, issue an IN and collect one packet from the encoder side
   task automatic in_pkt(input string tag, input int n, input int off, input logic [7:0] base,
                         input logic exp_par);
      int   guard = 0;
      int   k = 0;
      int   bad = 0;
      bit   done = 1'b0;
      logic par = 1'bx;
      while (ep_ready_o !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      chk({tag, "_ready"}, 32'(ep_ready_o), 32'd1);
      selected_i = 1'b1;
      step();
      selected_i = 1'b0;
      guard = 0;
      while (!done && guard < 3000) begin
         @(negedge clock);
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (k == 0) par = parity_o;
            if (m_tdata !== pat(off + k, base) || m_tkeep !== 1'b1 || m_tlast !== (k == n - 1)) bad++;
            done = (m_tlast === 1'b1);
            k++;
         end
         step();
         guard++;
      end
      chk({tag, "_len"}, 32'(k), 32'(n));
      chk({tag, "_bad_beats"}, 32'(bad), 32'd0);
      chk({tag, "_parity"}, 32'(par), 32'(exp_par));
   endtask

   initial begin
      // Reset: HALT, everything quiet
      #2;
      chk("rst_stalled", 32'(stalled_o), 32'd1);
      chk("rst_ready", 32'(ep_ready_o), 32'd0);
      chk("rst_parity", 32'(parity_o), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      step();
      step();
      reset = 1'b0;
      step();

      // 1: single short packet
      conf();
      chk("conf_stalled", 32'(stalled_o), 32'd0);
      chk("conf_s_tready", 32'(s_tready), 32'd1);
      chk("conf_ready", 32'(ep_ready_o), 32'd0);
      push(100, 8'h00, 1'b1);
      in_pkt("t1", 100, 0, 8'h00, 1'b0);
      pulse_ack();
      chk("t1_parity_after", 32'(parity_o), 32'd1);
      step();
      step();
      chk("t1_ready_after", 32'(ep_ready_o), 32'd0);

      // 2: 1200-byte frame split 512/512/176
      conf();
      chk("t2_parity_conf", 32'(parity_o), 32'd0);
      push(1200, 8'h10, 1'b1);
      in_pkt("t2a", 512, 0, 8'h10, 1'b0);
      pulse_ack();
      in_pkt("t2b", 512, 512, 8'h10, 1'b1);
      pulse_ack();
      in_pkt("t2c", 176, 1024, 8'h10, 1'b0);
      pulse_ack();
      step();
      step();
      chk("t2_parity_end", 32'(parity_o), 32'd1);
      chk("t2_ready_end", 32'(ep_ready_o), 32'd0);

      // 3: timeout forces identical resend, parity toggles once
      conf();
      push(64, 8'h80, 1'b1);
      in_pkt("t3a", 64, 0, 8'h80, 1'b0);
      pulse_tmo();
      chk("t3_parity_tmo", 32'(parity_o), 32'd0);
      in_pkt("t3b", 64, 0, 8'h80, 1'b0);
      pulse_ack();
      chk("t3_parity_ack", 32'(parity_o), 32'd1);

      // 4: frame ending exactly on a full packet
      conf();
      push(512, 8'h40, 1'b1);
      in_pkt("t4", 512, 0, 8'h40, 1'b0);
      pulse_ack();
`ifdef BULK_IN_ZDP_EN
      step();
      step();
      chk("t4_zdp_ready", 32'(ep_ready_o), 32'd1);
      selected_i = 1'b1;
      step();
      selected_i = 1'b0;
      @(negedge clock);
      chk("t4_zdp_valid", 32'(m_tvalid), 32'd1);
      chk("t4_zdp_keep", 32'(m_tkeep), 32'd0);
      chk("t4_zdp_last", 32'(m_tlast), 32'd1);
      chk("t4_zdp_data", 32'(m_tdata), 32'd0);
      step();
      pulse_ack();
`endif
      step();
      step();
      chk("t4_ready_end", 32'(ep_ready_o), 32'd0);

      // 5: fill the FIFO without INs, then free one packet
      conf();
      push(2048, 8'h00, 1'b0);
      step();
      chk("t5_full_s_tready", 32'(s_tready), 32'd0);
      in_pkt("t5", 512, 0, 8'h00, 1'b0);
      pulse_ack();
      step();
      chk("t5_freed_s_tready", 32'(s_tready), 32'd1);
      chk("t5_ready_more", 32'(ep_ready_o), 32'd1);

      // 6: clr_conf_i during a stalled SEND
      conf();
      push(64, 8'h20, 1'b1);
      m_tready = 1'b0;
      step();
      step();
      chk("t6_ready", 32'(ep_ready_o), 32'd1);
      selected_i = 1'b1;
      step();
      selected_i = 1'b0;
      step();
      chk("t6_send_valid", 32'(m_tvalid), 32'd1);
      clr_conf_i = 1'b1;
      step();
      chk("t6_stalled", 32'(stalled_o), 32'd1);
      chk("t6_valid_drop", 32'(m_tvalid), 32'd0);
      clr_conf_i = 1'b0;
      m_tready = 1'b1;
      selected_i = 1'b1;
      step();
      selected_i = 1'b0;
      step();
      chk("t6_still_stalled", 32'(stalled_o), 32'd1);
      chk("t6_no_valid", 32'(m_tvalid), 32'd0);
      chk("t6_no_ready", 32'(ep_ready_o), 32'd0);
      chk("t6_no_s_tready", 32'(s_tready), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
